// File: rtl/i2c_pkg.sv
// Shared definitions for the canvas-chip I2C link (controller and target side).
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RD_BYTE,
    ST_M_ACK,
    ST_STOP
  } state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } phase_e;

  localparam logic        RD_BIT     = 1'b1;
  localparam int unsigned REG_BYTES  = 3;
  localparam logic [1:0]  IDX_X      = 2'd0;
  localparam logic [1:0]  IDX_Y      = 2'd1;
  localparam logic [1:0]  IDX_STATUS = 2'd2;

endpackage

// File: rtl/i2c_bit_timer.sv
// Bit-cell timebase: four quarters of CLK_DIV cycles each, with SCL stretch hold in Q2.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   run_i,
  input  logic   scl_i,
  output phase_e phase_o,
  output logic   sample_o,
  output logic   cell_end_o
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  phase_e      phase_q, phase_d;
  logic        last;

  assign last = (cnt_q == LAST);

  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (phase_q == Q2 && !scl_i) begin
      // Target is stretching: Q2 restarts its full quarter once SCL is seen high.
      cnt_d = '0;
    end else if (last) begin
      cnt_d   = '0;
      phase_d = phase_e'(phase_q + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o    = phase_q;
  assign sample_o   = run_i && (phase_q == Q2) && last && scl_i;
  assign cell_end_o = run_i && (phase_q == Q3) && last;

endmodule

// File: rtl/i2c_canvas_reader.sv
// I2C controller that reads the 3-byte {x_pos, y_pos, status} block from the canvas chip.
module i2c_canvas_reader #(
  parameter logic [6:0]  TARGET_ADDR = 7'h64,
  parameter int unsigned CLK_DIV     = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic [7:0] status,
  output logic       data_valid,
  input  logic       scl_in,
  output logic       scl_oe,
  input  logic       sda_in,
  output logic       sda_oe
);
  import i2c_pkg::*;

  localparam logic [7:0] ADDR_BYTE = {TARGET_ADDR, RD_BIT};

  state_e                     state_q, state_d;
  phase_e                     phase;
  logic                       sample, cell_end, scl_low;
  logic [2:0]                 bit_cnt_q;
  logic [1:0]                 byte_idx_q;
  logic [7:0]                 shift_q;
  logic [REG_BYTES-1:0][7:0]  shadow_q;
  logic                       done_q, ack_err_q, valid_q;
  logic [7:0]                 x_q, y_q, st_q;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run_i      (state_q != ST_IDLE),
    .scl_i      (scl_in),
    .phase_o    (phase),
    .sample_o   (sample),
    .cell_end_o (cell_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start) state_d = ST_START;
      ST_START:    if (cell_end) state_d = ST_ADDR;
      ST_ADDR:     if (cell_end && bit_cnt_q == 3'd7) state_d = ST_ADDR_ACK;
      ST_ADDR_ACK: if (cell_end) state_d = ack_err_q ? ST_STOP : ST_RD_BYTE;
      ST_RD_BYTE:  if (cell_end && bit_cnt_q == 3'd7) state_d = ST_M_ACK;
      ST_M_ACK:    if (cell_end) state_d = (byte_idx_q == IDX_STATUS) ? ST_STOP : ST_RD_BYTE;
      ST_STOP:     if (cell_end) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign scl_low = (phase == Q0) || (phase == Q1);

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      ST_START: sda_oe = !scl_low;
      ST_ADDR: begin
        scl_oe = scl_low;
        sda_oe = ~ADDR_BYTE[~bit_cnt_q];
      end
      ST_ADDR_ACK, ST_RD_BYTE: scl_oe = scl_low;
      ST_M_ACK: begin
        scl_oe = scl_low;
        sda_oe = (byte_idx_q != IDX_STATUS);
      end
      ST_STOP: begin
        scl_oe = (phase == Q0);
        sda_oe = scl_low;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      st_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        ack_err_q  <= 1'b0;
        bit_cnt_q  <= '0;
        byte_idx_q <= '0;
      end
      if (cell_end && (state_q == ST_ADDR || state_q == ST_RD_BYTE))
        bit_cnt_q <= bit_cnt_q + 3'd1;
      if (sample && state_q == ST_ADDR_ACK)
        ack_err_q <= sda_in;
      if (sample && state_q == ST_RD_BYTE) begin
        shift_q <= {shift_q[6:0], sda_in};
        if (bit_cnt_q == 3'd7) shadow_q[byte_idx_q] <= {shift_q[6:0], sda_in};
      end
      if (cell_end && state_q == ST_M_ACK && byte_idx_q != IDX_STATUS)
        byte_idx_q <= byte_idx_q + 2'd1;
      // Visible outputs only change as a set, and only after an acknowledged read.
      if (cell_end && state_q == ST_STOP) begin
        done_q <= 1'b1;
        if (!ack_err_q) begin
          x_q     <= shadow_q[IDX_X];
          y_q     <= shadow_q[IDX_Y];
          st_q    <= shadow_q[IDX_STATUS];
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign ack_err    = ack_err_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign status     = st_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_i2c_canvas_reader.sv
// Scoreboard bench for i2c_canvas_reader against a behavioural canvas-chip target on the bus.
module tb_i2c_canvas_reader;

  localparam int DIV = 4;

  typedef struct {
    logic [7:0] x, y, s;
    logic       err, valid;
    int         lat;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       busy, done, ack_err, data_valid, scl_oe, sda_oe, scl_in, sda_in;
  logic [7:0] x_pos, y_pos, status;

  logic       tgt_hold = 1'b0, tgt_sda_low = 1'b0, tdrive = 1'b0, stretch_en = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [6:0] tgt_addr = 7'h64;
  logic [7:0] tdata [3];
  logic [7:0] rx_addr = '0;
  logic [2:0] mack = '0;
  int         nrise = -1, hold_cnt = 0, starts = 0, stops = 0;
  int         cyc = 0, t_acc = 0, starts_acc = 0, stops_acc = 0, dones = 0;
  int         n_checks = 0, n_pass = 0;
  exp_t       sb [$];
  exp_t       ea, eb, en;

  assign scl_in = ~scl_oe & ~tgt_hold;
  assign sda_in = ~sda_oe & ~tgt_sda_low;

  i2c_canvas_reader #(.TARGET_ADDR(7'h64), .CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .status     (status),
    .data_valid (data_valid),
    .scl_in     (scl_in),
    .scl_oe     (scl_oe),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Target at tgt_addr: ACKs its address, shifts out tdata MSB first, optionally stretches.
  initial begin : target_model
    logic scl, sda, match;
    int   b, k;
    forever begin
      @(negedge clk);
      scl = scl_in;
      sda = sda_in;
      match = (rx_addr == {tgt_addr, 1'b1});
      if (hold_cnt > 0) hold_cnt--;
      if (rst) begin
        nrise = -1; tdrive = 1'b0; hold_cnt = 0;
      end else if (prev_scl && scl && prev_sda && !sda) begin
        starts++; nrise = 0; rx_addr = '0; tdrive = 1'b0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        stops++; nrise = -1; tdrive = 1'b0;
      end else if (!prev_scl && scl && nrise >= 0) begin
        if (nrise < 8) rx_addr = {rx_addr[6:0], sda};
        else if (nrise == 17) mack[0] = sda;
        else if (nrise == 26) mack[1] = sda;
        else if (nrise == 35) mack[2] = sda;
        nrise++;
      end else if (prev_scl && !scl && nrise >= 0) begin
        if (stretch_en && nrise == 20) hold_cnt = 2 * DIV + 20;
        b = (nrise - 9) / 9;
        k = (nrise - 9) % 9;
        if (nrise == 8) tdrive = match;
        else if (nrise >= 9 && nrise <= 34 && k != 8) tdrive = match && !tdata[b][7-k];
        else tdrive = 1'b0;
      end
      tgt_hold    = (hold_cnt > 0);
      // While stretching, present the wrong bit so an early sample corrupts the byte.
      tgt_sda_low = (hold_cnt > 1) ? ~tdrive : tdrive;
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  initial begin : monitor
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        dones++;
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          lat = cyc - t_acc;
          check_eq($sformatf("latency=%0d want=%0d+-1", lat, e.lat),
                   32'(lat >= e.lat - 1 && lat <= e.lat + 1), 32'd1);
          check_eq("ack_err", 32'(ack_err), 32'(e.err));
          check_eq("x_pos", 32'(x_pos), 32'(e.x));
          check_eq("y_pos", 32'(y_pos), 32'(e.y));
          check_eq("status", 32'(status), 32'(e.s));
          check_eq("data_valid", 32'(data_valid), 32'(e.valid));
          check_eq("busy_at_done", 32'(busy), 32'd0);
          check_eq("bus_addr", 32'(rx_addr), 32'hC9);
          check_eq("bus_starts", 32'(starts - starts_acc), 32'd1);
          check_eq("bus_stops", 32'(stops - stops_acc), 32'd1);
          if (!e.err) check_eq("bus_master_ack", 32'(mack), 32'b100);
        end
      end
    end
  end

  task automatic pulse_start(input exp_t e);
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start      = 1'b0;
    t_acc      = cyc;
    starts_acc = starts;
    stops_acc  = stops;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max);
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic idle_checks(input string tag);
    check_eq({tag, "_scl_oe"}, 32'(scl_oe), 32'd0);
    check_eq({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_ack_err"}, 32'(ack_err), 32'd0);
    check_eq({tag, "_outs"}, {8'h0, x_pos, y_pos, status}, 32'd0);
    check_eq({tag, "_valid"}, 32'(data_valid), 32'd0);
  endtask

  initial begin
    int n;
    tdata = '{8'h12, 8'h34, 8'h8B};
    ea = '{x: 8'h12, y: 8'h34, s: 8'h8B, err: 1'b0, valid: 1'b1, lat: 608};
    eb = '{x: 8'hFF, y: 8'h00, s: 8'h0F, err: 1'b0, valid: 1'b1, lat: 608};
    en = '{x: 8'h00, y: 8'h00, s: 8'h00, err: 1'b1, valid: 1'b0, lat: 176};

    repeat (4) @(negedge clk);
    idle_checks("reset");
    rst = 1'b0;
    @(negedge clk);

    tgt_addr = 7'h22;
    pulse_start(en);
    wait_done(400);
    tgt_addr = 7'h64;

    @(negedge clk);
    pulse_start(ea);
    wait_done(800);

    stretch_en = 1'b1;
    @(negedge clk);
    ea.lat = 628;
    pulse_start(ea);
    ea.lat = 608;
    wait_done(900);
    stretch_en = 1'b0;

    @(negedge clk);
    pulse_start(ea);
    repeat (99) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_during_extra_start", 32'(busy), 32'd1);
    wait_done(800);

    @(negedge clk);
    pulse_start(ea);
    n = 0;
    while (!(nrise == 20 && scl_oe) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_y_byte", 32'(nrise), 32'd20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle_checks("mid_reset");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pulse_start(ea);
    wait_done(800);
    tdata = '{8'hFF, 8'h00, 8'h0F};
    pulse_start(eb);
    repeat (300) @(negedge clk);
    check_eq("hold_x_pos", 32'(x_pos), 32'h12);
    check_eq("hold_y_pos", 32'(y_pos), 32'h34);
    check_eq("hold_status", 32'(status), 32'h8B);
    check_eq("hold_valid", 32'(data_valid), 32'd1);
    wait_done(800);

    repeat (8) @(negedge clk);
    check_eq("done_count", 32'(dones), 32'd6);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
